vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of vga_timing_gen: pixel strobe, x/y to the colour source,
// colour back, and the registered DAC/sync outputs.
interface vga_timing_gen_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       frame_start;

    modport master (
        input  pix_en, r, g, b,
        output x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, frame_start
    );

    modport slave (
        output pix_en, r, g, b,
        input  x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with one-pixel registered DAC/sync outputs.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]        frame_cnt,
`endif
    vga_timing_gen_if.master   vga
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_VIS  = CNT_W'(H_ACTIVE);
    localparam cnt_t H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam cnt_t H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t H_LAST = CNT_W'(H_TOTAL - 1);
    localparam cnt_t V_VIS  = CNT_W'(V_ACTIVE);
    localparam cnt_t V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam cnt_t V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam cnt_t V_LAST = CNT_W'(V_TOTAL - 1);

    cnt_t             hc_q, hc_d;
    cnt_t             vc_q, vc_d;
    logic [COL_W-1:0] r_q, g_q, b_q;
    logic [COL_W-1:0] r_d, g_d, b_d;
    logic             hs_q, vs_q, blank_n_q, fs_q;

    logic             visible_c;
    logic             hs_raw_c;
    logic             vs_raw_c;
    logic             line_end_c;
    logic             first_px_c;

    // Raster decode and counter next-state for the pixel currently on x/y.
    always_comb begin
        visible_c  = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs_raw_c   = !((hc_q >= H_SS) && (hc_q < H_SE));
        vs_raw_c   = !((vc_q >= V_SS) && (vc_q < V_SE));
        line_end_c = (hc_q == H_LAST);
        first_px_c = vga.pix_en && (hc_q == '0) && (vc_q == '0);

        hc_d = hc_q;
        vc_d = vc_q;
        if (vga.pix_en) begin
            hc_d = line_end_c ? '0 : hc_q + cnt_t'(1);
            if (line_end_c) begin
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + cnt_t'(1);
            end
        end

        r_d = visible_c ? vga.r : '0;
        g_d = visible_c ? vga.g : '0;
        b_d = visible_c ? vga.b : '0;
    end

    // frame_start is cleared on idle strobe cycles so it stays a single-clk pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q      <= '0;
            vc_q      <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fs_q <= first_px_c;
            if (vga.pix_en) begin
                r_q       <= r_d;
                g_q       <= g_d;
                b_q       <= b_d;
                hs_q      <= hs_raw_c;
                vs_q      <= vs_raw_c;
                blank_n_q <= visible_c;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (first_px_c) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign vga.x           = hc_q;
    assign vga.y           = vc_q;
    assign vga.vga_r       = r_q;
    assign vga.vga_g       = g_q;
    assign vga.vga_b       = b_q;
    assign vga.vga_hs      = hs_q;
    assign vga.vga_vs      = vs_q;
    assign vga.vga_blank_n = blank_n_q;
    assign vga.vga_sync_n  = 1'b0;
    assign vga.frame_start = fs_q;

endmodule
